// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the L1-to-memory burst arbiter.
// Package name follows the codebase's namespace style (mem_arb::).
package mem_arb;

  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = LINE_W / BEAT_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_FILL = 3'd1,
    D_FILL = 3'd2,
    D_WB   = 3'd3,
    DONE   = 3'd4
  } arb_state_t;

  typedef enum logic {
    own_i = 1'b0,
    own_d = 1'b1
  } owner_t;

endpackage

// File: rtl/cache_mem_arbiter_checker.sv
// Protocol checks for the arbiter's requester and memory sides.
// Simulation-only intent; synthesis tools drop the assertions.
module cache_mem_arbiter_checker
  import mem_arb::*;
(
  input logic       clk,
  input logic       rst,
  input arb_state_t state,
  input logic       d_read,
  input logic       d_write,
  input logic       mem_resp
);

  // The D-cache must never ask for a fill and a write-back at once.
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(d_read && d_write))
    else $error("arbiter: d_read and d_write asserted together");

  // Memory must only answer while a burst is being driven.
  a_resp_in_burst: assert property (@(posedge clk) disable iff (!rst)
    mem_resp |-> ((state != IDLE) && (state != DONE)))
    else $error("arbiter: mem_resp outside a burst");

endmodule

// File: rtl/cache_mem_arbiter_line_burst_buffer.sv
// Line-wide staging register for burst transfers: whole-line load for
// write-backs, per-beat slice write for fills, beat-slice read mux for the
// outgoing write beat, and a beat counter that wraps after the last beat.
module line_burst_buffer #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [LINE_W-1:0] load_line,
  input  logic              beat_we,
  input  logic              beat_adv,
  input  logic [BEAT_W-1:0] beat_wdata,
  output logic [LINE_W-1:0] line,
  output logic [BEAT_W-1:0] beat_rdata,
  output logic              last_beat
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  logic [LINE_W-1:0] line_r;
  logic [CNT_W-1:0]  cnt_r;

  assign line       = line_r;
  assign beat_rdata = line_r[cnt_r*BEAT_W +: BEAT_W];
  assign last_beat  = (cnt_r == CNT_LAST);

  // Line storage: parallel load wins over a beat write; beat 0 is the low slice.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_r <= {LINE_W{1'b0}};
    end else if (load_en) begin
      line_r <= load_line;
    end else if (beat_we) begin
      line_r[cnt_r*BEAT_W +: BEAT_W] <= beat_wdata;
    end else begin
      line_r <= line_r;
    end
  end

  // Beat index: restarts on a line load, advances per accepted beat, wraps after the last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= CNT_ZERO;
    end else if (load_en) begin
      cnt_r <= CNT_ZERO;
    end else if (beat_adv) begin
      cnt_r <= last_beat ? CNT_ZERO : (cnt_r + CNT_ONE);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbiter sharing the memory burst port between the I-cache (line fills) and
// the D-cache (line fills and write-backs). One 256-bit line moves as a
// BEATS-long burst of 64-bit beats; the grant holds until the line completes.
// Optional macro ARB_ROUND_ROBIN_EN: when both caches request in IDLE the one
// not served last wins; otherwise the D-cache has fixed priority.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = mem_arb::LINE_W,
  parameter int BEAT_W = mem_arb::BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  import mem_arb::*;

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF_W;

  arb_state_t        state_r, state_s;
  owner_t            owner_r, owner_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] req_addr_s;
  logic              d_req_s;
  logic              pick_d_s;
  logic              grant_s;
  logic              load_s;
  logic              beat_we_s;
  logic              beat_adv_s;
  logic [LINE_W-1:0] line_s;
  logic [BEAT_W-1:0] beat_rdata_s;
  logic              last_beat_s;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_owner_r;

  // Remember who won the last grant so simultaneous requests alternate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_r <= own_i;
    end else if (grant_s) begin
      last_owner_r <= owner_s;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end
`endif

  // Grant choice in IDLE: D-side wins unless round-robin hands a tie to I.
  always_comb begin
    d_req_s = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
    if (d_req_s && i_read) begin
      pick_d_s = (last_owner_r == own_i);
    end else begin
      pick_d_s = d_req_s;
    end
`else
    pick_d_s = d_req_s;
`endif
    req_addr_s = pick_d_s ? d_addr : i_addr;
  end

  // Next-state and datapath control; requests are only looked at in IDLE.
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    grant_s    = 1'b0;
    load_s     = 1'b0;
    beat_we_s  = 1'b0;
    beat_adv_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_d_s) begin
          grant_s = 1'b1;
          owner_s = own_d;
          if (d_write) begin
            state_s = D_WB;
            load_s  = 1'b1;
          end else begin
            state_s = D_FILL;
          end
        end else if (i_read) begin
          grant_s = 1'b1;
          owner_s = own_i;
          state_s = I_FILL;
        end else begin
          state_s = IDLE;
        end
      end
      I_FILL, D_FILL: begin
        beat_we_s  = mem_resp;
        beat_adv_s = mem_resp;
        if (mem_resp && last_beat_s) begin
          state_s = DONE;
        end else begin
          state_s = state_r;
        end
      end
      D_WB: begin
        beat_adv_s = mem_resp;
        if (mem_resp && last_beat_s) begin
          state_s = DONE;
        end else begin
          state_s = D_WB;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state and current owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      owner_r <= own_i;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
    end
  end

  // Line-aligned burst address captured at grant, stable for the whole burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r <= {ADDR_W{1'b0}};
    end else if (grant_s) begin
      addr_r <= req_addr_s & ALIGN_MASK;
    end else begin
      addr_r <= addr_r;
    end
  end

  line_burst_buffer #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_s),
    .load_line  (d_wdata),
    .beat_we    (beat_we_s),
    .beat_adv   (beat_adv_s),
    .beat_wdata (mem_rdata),
    .line       (line_s),
    .beat_rdata (beat_rdata_s),
    .last_beat  (last_beat_s)
  );

  cache_mem_arbiter_checker u_chk (
    .clk      (clk),
    .rst      (rst),
    .state    (state_r),
    .d_read   (d_read),
    .d_write  (d_write),
    .mem_resp (mem_resp)
  );

  // Outputs decode from registered state only; memory side idles at zero.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {BEAT_W{1'b0}};
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    case (state_r)
      I_FILL, D_FILL: begin
        mem_read = 1'b1;
        mem_addr = addr_r;
      end
      D_WB: begin
        mem_write = 1'b1;
        mem_addr  = addr_r;
        mem_wdata = beat_rdata_s;
      end
      DONE: begin
        i_resp = (owner_r == own_i);
        d_resp = (owner_r == own_d);
      end
      default: begin
        mem_read = 1'b0;
      end
    endcase
  end

  assign i_rdata = line_s;
  assign d_rdata = line_s;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus a random
// request mix, checked against a transaction-level model of grant order,
// aligned addresses, beat ordering and response timing.
module tb_cache_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_addr;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int vectors;
  int miscompares;
  int cyc;
  bit last_d;

  cache_mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_read"},  256'(mem_read),  256'd0);
    chk({tag, ".mem_write"}, 256'(mem_write), 256'd0);
    chk({tag, ".mem_addr"},  256'(mem_addr),  256'd0);
    chk({tag, ".mem_wdata"}, 256'(mem_wdata), 256'd0);
    chk({tag, ".i_resp"},    256'(i_resp),    256'd0);
    chk({tag, ".d_resp"},    256'(d_resp),    256'd0);
    chk({tag, ".i_rdata"},   i_rdata,         256'd0);
    chk({tag, ".d_rdata"},   d_rdata,         256'd0);
  endtask

  task automatic hold_chk(input bit wr, input logic [31:0] ea, input logic [255:0] wl, input int k);
    chk("burst.mem_read",  256'(mem_read),  256'(!wr));
    chk("burst.mem_write", 256'(mem_write), 256'(wr));
    chk("burst.mem_addr",  256'(mem_addr),  256'(ea));
    if (wr) chk("burst.mem_wdata", 256'(mem_wdata), 256'(wl[k*64 +: 64]));
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (mem_read || mem_write) ok = 1'b1;
      else @(negedge clk);
    end
    chk("burst_start_timeout", 256'(ok), 256'd1);
  endtask

  // Memory side of one line: four beats with gaps drawn from [glo, ghi].
  task automatic serve(input bit wr, input logic [31:0] ea, input logic [255:0] wl,
                       input int glo, input int ghi, input bit fixed_beats,
                       input bit raise_d, output logic [255:0] rl);
    logic [63:0] beat;
    logic [3:0]  nib;
    int g;
    rl = 256'd0;
    for (int k = 0; k < 4; k++) begin
      if (raise_d && k == 1) d_read = 1'b1;
      g = int'($urandom_range(ghi, glo));
      for (int j = 0; j < g; j++) begin
        mem_resp = 1'b0;
        hold_chk(wr, ea, wl, k);
        @(negedge clk);
      end
      hold_chk(wr, ea, wl, k);
      nib  = 4'(k + 1);
      beat = fixed_beats ? {16{nib}} : {$urandom, $urandom};
      mem_rdata = beat;
      mem_resp  = 1'b1;
      rl[k*64 +: 64] = beat;
      @(negedge clk);
    end
    mem_resp  = 1'b0;
    mem_rdata = 64'd0;
  endtask

  // One arbitration episode: raise requests, predict grant order, serve and check each line.
  task automatic run_pair(input bit want_i, input bit want_d, input bit d_wr, input bit late_d,
                          input logic [31:0] ia, input logic [31:0] da, input logic [255:0] wl,
                          input int glo, input int ghi, input bit fixed_beats, output int lat);
    bit first_d;
    bit have_second;
    bit cur_d;
    bit ok;
    bit exp_wr;
    int t0;
    logic [31:0]  exp_addr;
    logic [255:0] rl;
    logic [255:0] exp_line;
    i_addr  = ia;
    d_addr  = da;
    d_wdata = wl;
    i_read  = want_i;
    d_read  = want_d && !d_wr && !late_d;
    d_write = want_d && d_wr && !late_d;
    first_d     = want_d && !late_d && (!want_i || !RR_MODE || !last_d);
    have_second = want_i && want_d;
    t0  = cyc;
    lat = 0;
    for (int x = 0; x < (have_second ? 2 : 1); x++) begin
      cur_d = (x == 0) ? first_d : !first_d;
      if (x == 1) begin
        @(negedge clk);
        chk("idle_gap.busy", 256'(mem_read | mem_write), 256'd0);
        @(negedge clk);
        chk("b2b_start", 256'(mem_read | mem_write), 256'd1);
      end
      wait_busy(ok);
      if (!ok) begin
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        return;
      end
      exp_addr = (cur_d ? da : ia) & 32'hFFFF_FFE0;
      exp_wr   = cur_d && d_wr;
      serve(exp_wr, exp_addr, wl, glo, ghi, fixed_beats, late_d && (x == 0), rl);
      if (x == 0) lat = cyc - t0;
      chk("done.i_resp",    256'(i_resp),    256'(!cur_d));
      chk("done.d_resp",    256'(d_resp),    256'(cur_d));
      chk("done.mem_read",  256'(mem_read),  256'd0);
      chk("done.mem_write", 256'(mem_write), 256'd0);
      exp_line = exp_wr ? wl : rl;
      chk("done.rdata", cur_d ? d_rdata : i_rdata, exp_line);
      if (cur_d) begin
        d_read = 1'b0; d_write = 1'b0;
      end else begin
        i_read = 1'b0;
      end
      last_d = cur_d;
    end
    @(negedge clk);
    chk("after.i_resp", 256'(i_resp), 256'd0);
    chk("after.d_resp", 256'(d_resp), 256'd0);
  endtask

  initial begin
    int lat;
    int r;
    vectors = 0; miscompares = 0; cyc = 0; last_d = 1'b0;
    rst = 1'b0;
    i_read = 1'b0; i_addr = 32'd0;
    d_read = 1'b0; d_write = 1'b0; d_addr = 32'd0; d_wdata = 256'd0;
    mem_rdata = 64'd0; mem_resp = 1'b0;

    // Reset state
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    // I fill from 0x1234 with fixed beats and consecutive mem_resp
    run_pair(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'd0, 256'd0, 0, 0, 1'b1, lat);
    chk("i_fill.latency", 256'(lat), 256'd5);
    chk("i_fill.line", i_rdata,
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

    // Simultaneous I and D fills, twice (second pair exercises round-robin)
    run_pair(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0200, 256'd0, 0, 1, 1'b0, lat);
    run_pair(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0200, 256'd0, 0, 1, 1'b0, lat);

    // D write-back with two idle cycles before each mem_resp
    run_pair(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h4000_0040,
             {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
             2, 2, 1'b0, lat);

    // d_read raised in the middle of an I fill
    run_pair(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0447, 256'd0, 0, 1, 1'b0, lat);

    // Reset after two of four beats
    i_addr = 32'h0000_0abc;
    i_read = 1'b1;
    @(negedge clk);
    chk("rst_mid.busy", 256'(mem_read), 256'd1);
    mem_rdata = 64'hdead_beef_0000_0001; mem_resp = 1'b1;
    @(negedge clk);
    mem_rdata = 64'hdead_beef_0000_0002; mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0; mem_rdata = 64'd0;
    #2 rst = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    i_read = 1'b0;
    last_d = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("rst_mid.no_resp", 256'(i_resp | d_resp), 256'd0);
    end
    run_pair(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0abc, 32'd0, 256'd0, 0, 2, 1'b0, lat);

    // Random request mix
    for (int it = 0; it < 24; it++) begin
      r = int'($urandom_range(3, 0));
      run_pair(r != 1, r != 0, 1'($urandom_range(1, 0)), 1'b0, $urandom, $urandom,
               {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
               0, 3, 1'b0, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
